hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/pipeline_types.sv | 13 +
 rtl/load_use_detect.sv | 19 +
 rtl/hazard_unit.sv | 136 +++++++++++++
 tb/tb_hazard_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_types.sv
// Shared types for the pipeline control logic: hazard FSM states and register index width.
package pipeline_types;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    IMEM_WAIT = 2'd2,
    DROP      = 2'd3
  } hazard_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the decode instruction reads a register the load in execute writes.
module load_use_detect
  import pipeline_types::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  output logic                 hit
);

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign hit = ex_is_load && (ex_rd != '0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: freezes, flushes, load-use bubbles and fetch stalls.
// Define HAZARD_PERF_EN to build the saturating perf counters; otherwise perf_* read 0.
module hazard_unit
  import pipeline_types::*;
#(
  parameter int PERF_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_br_taken,
  input  logic                 imem_read,
  input  logic                 imem_resp,
  input  logic                 mem_req,
  input  logic                 dmem_resp,
  output logic                 load_pc,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 nop_if_id,
  output logic                 nop_id_ex,
  output logic [PERF_W-1:0]    perf_stall,
  output logic [PERF_W-1:0]    perf_flush,
  output logic [PERF_W-1:0]    perf_lduse,
  output logic [1:0]           state_dbg
);

  hazard_state_t state_q, state_d;
  logic lduse_hit;
  logic dstall, istall;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .hit         (lduse_hit)
  );

  assign dstall    = mem_req && !dmem_resp;
  assign istall    = imem_read && !imem_resp;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    load_pc     = 1'b1;
    load_if_id  = 1'b1;
    load_id_ex  = 1'b1;
    load_ex_mem = 1'b1;
    load_mem_wb = 1'b1;
    nop_if_id   = 1'b0;
    nop_id_ex   = 1'b0;
    state_d     = RUN;
    if (rst) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else if (dstall) begin
      // Full freeze; a pending redirect or load-use is re-evaluated once it lifts.
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      state_d     = (state_q == DROP && !imem_resp) ? DROP : DMEM_WAIT;
    end else if (ex_br_taken) begin
      nop_if_id = 1'b1;
      nop_id_ex = 1'b1;
      if (state_q == DROP) state_d = imem_resp ? RUN : DROP;
      else                 state_d = istall ? DROP : RUN;
    end else if (state_q == DROP) begin
      // Wrong-path fetch still in flight: hold the PC until its response is thrown away.
      nop_if_id = 1'b1;
      load_pc   = imem_resp;
      if (lduse_hit) begin
        load_pc    = 1'b0;
        load_if_id = 1'b0;
        nop_id_ex  = 1'b1;
      end
      state_d = imem_resp ? RUN : DROP;
    end else if (lduse_hit) begin
      load_pc    = 1'b0;
      load_if_id = 1'b0;
      nop_id_ex  = 1'b1;
      state_d    = istall ? IMEM_WAIT : RUN;
    end else if (istall) begin
      load_pc   = 1'b0;
      nop_if_id = 1'b1;
      state_d   = IMEM_WAIT;
    end
  end

`ifdef HAZARD_PERF_EN
  logic              stall_ev, flush_ev, lduse_ev;
  logic [PERF_W-1:0] stall_q, flush_q, lduse_q;

  assign stall_ev = !rst && !load_pc;
  assign flush_ev = !rst && !dstall && ex_br_taken;
  assign lduse_ev = !rst && !dstall && !ex_br_taken && lduse_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      lduse_q <= '0;
    end else begin
      if (stall_ev && (stall_q != '1)) stall_q <= stall_q + PERF_W'(1);
      if (flush_ev && (flush_q != '1)) flush_q <= flush_q + PERF_W'(1);
      if (lduse_ev && (lduse_q != '1)) lduse_q <= lduse_q + PERF_W'(1);
    end
  end

  assign perf_stall = stall_q;
  assign perf_flush = flush_q;
  assign perf_lduse = lduse_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
  assign perf_lduse = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; perf expectations follow HAZARD_PERF_EN.
module tb_hazard_unit;

`ifdef HAZARD_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, nop_if_id, nop_id_ex}
  localparam logic [6:0] ZERO     = 7'b00000_00;
  localparam logic [6:0] RUN_ALL  = 7'b11111_00;
  localparam logic [6:0] FREEZE   = 7'b00000_00;
  localparam logic [6:0] FLUSH    = 7'b11111_11;
  localparam logic [6:0] LDUSE    = 7'b00111_01;
  localparam logic [6:0] ISTALL   = 7'b01111_10;
  localparam logic [6:0] DROPWAIT = 7'b01111_10;
  localparam logic [6:0] DROPRESP = 7'b11111_10;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_DMEM = 2'd1;
  localparam logic [1:0] S_IMEM = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_br_taken;
  logic        imem_read, imem_resp, mem_req, dmem_resp;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        nop_if_id, nop_id_ex;
  logic [31:0] perf_stall, perf_flush, perf_lduse;
  logic [1:0]  state_dbg;
  logic [31:0] exp_v;
  wire  [6:0]  outs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, nop_if_id, nop_id_ex};

  int errors = 0;
  int checks = 0;

  hazard_unit #(.PERF_W(32)) dut (
    .clk (clk), .rst (rst),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2),
    .id_uses_rs1 (id_uses_rs1), .id_uses_rs2 (id_uses_rs2),
    .ex_rd (ex_rd), .ex_is_load (ex_is_load), .ex_br_taken (ex_br_taken),
    .imem_read (imem_read), .imem_resp (imem_resp),
    .mem_req (mem_req), .dmem_resp (dmem_resp),
    .load_pc (load_pc), .load_if_id (load_if_id), .load_id_ex (load_id_ex),
    .load_ex_mem (load_ex_mem), .load_mem_wb (load_mem_wb),
    .nop_if_id (nop_if_id), .nop_id_ex (nop_id_ex),
    .perf_stall (perf_stall), .perf_flush (perf_flush), .perf_lduse (perf_lduse),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0; ex_br_taken = 1'b0;
    imem_read = 1'b0; imem_resp = 1'b0; mem_req = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); idle(); rst = 1'b1; ex_br_taken = 1'b1; imem_read = 1'b1;
    #1;
    checks++; if (outs !== ZERO) begin errors++; $display("FAIL reset_outs: got %b want %b", outs, ZERO); end
    @(negedge clk); #1;
    checks++; if (state_dbg !== S_RUN) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_RUN); end
    checks++; if ({perf_stall, perf_flush, perf_lduse} !== 96'd0) begin errors++; $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", perf_stall, perf_flush, perf_lduse); end
    rst = 1'b0; idle();
  endtask

  task automatic test_load_use();
    do_reset();
    // lw x5 in ex, add x6,x5,x1 in id
    @(negedge clk); ex_is_load = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_rs2 = 5'd1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    #1;
    checks++; if (outs !== LDUSE) begin errors++; $display("FAIL lduse_rs1: got %b want %b", outs, LDUSE); end
    @(negedge clk); ex_is_load = 1'b0; ex_rd = 5'd0; #1;
    checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL lduse_one_bubble: got %b want %b", outs, RUN_ALL); end
    exp_v = 32'(PERF_ON);
    checks++; if (perf_lduse !== exp_v) begin errors++; $display("FAIL lduse_perf_lduse: got %0d want %0d", perf_lduse, exp_v); end
    checks++; if (perf_stall !== exp_v) begin errors++; $display("FAIL lduse_perf_stall: got %0d want %0d", perf_stall, exp_v); end
    @(negedge clk); ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; #1;
    checks++; if (outs !== LDUSE) begin errors++; $display("FAIL lduse_rs2: got %b want %b", outs, LDUSE); end
    @(negedge clk); id_uses_rs2 = 1'b0; #1;
    checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL lduse_unused_src: got %b want %b", outs, RUN_ALL); end
    @(negedge clk); id_uses_rs2 = 1'b1; ex_is_load = 1'b0; #1;
    checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL lduse_not_load: got %b want %b", outs, RUN_ALL); end
    @(negedge clk); ex_is_load = 1'b1; imem_read = 1'b1; #1;
    checks++; if (outs !== LDUSE) begin errors++; $display("FAIL lduse_over_istall: got %b want %b", outs, LDUSE); end
    @(negedge clk); imem_read = 1'b0; ex_br_taken = 1'b1; #1;
    checks++; if (outs !== FLUSH) begin errors++; $display("FAIL redirect_over_lduse: got %b want %b", outs, FLUSH); end
    idle();
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk); ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; #1;
    checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL x0_no_stall: got %b want %b", outs, RUN_ALL); end
    @(negedge clk); idle(); #1;
    checks++; if (perf_lduse !== 32'd0) begin errors++; $display("FAIL x0_perf_lduse: got %0d want 0", perf_lduse); end
  endtask

  task automatic test_dstall();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_req = 1'b1; dmem_resp = 1'b0; #1;
      checks++; if (outs !== FREEZE) begin errors++; $display("FAIL dstall_freeze c%0d: got %b want %b", i, outs, FREEZE); end
    end
    checks++; if (state_dbg !== S_DMEM) begin errors++; $display("FAIL dstall_state: got %0d want %0d", state_dbg, S_DMEM); end
    @(negedge clk); dmem_resp = 1'b1; #1;
    checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL dstall_resp: got %b want %b", outs, RUN_ALL); end
    @(negedge clk); idle(); #1;
    checks++; if (state_dbg !== S_RUN) begin errors++; $display("FAIL dstall_back_run: got %0d want %0d", state_dbg, S_RUN); end
    exp_v = 32'(4 * PERF_ON);
    checks++; if (perf_stall !== exp_v) begin errors++; $display("FAIL dstall_perf_stall: got %0d want %0d", perf_stall, exp_v); end
  endtask

  task automatic test_istall();
    do_reset();
    @(negedge clk); imem_read = 1'b1; #1;
    checks++; if (outs !== ISTALL) begin errors++; $display("FAIL istall_outs: got %b want %b", outs, ISTALL); end
    @(negedge clk); #1;
    checks++; if (state_dbg !== S_IMEM) begin errors++; $display("FAIL istall_state: got %0d want %0d", state_dbg, S_IMEM); end
    @(negedge clk); imem_resp = 1'b1; #1;
    checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL istall_resp: got %b want %b", outs, RUN_ALL); end
    // both responses in one cycle
    @(negedge clk); idle(); mem_req = 1'b1; imem_read = 1'b1; #1;
    checks++; if (outs !== FREEZE) begin errors++; $display("FAIL both_freeze: got %b want %b", outs, FREEZE); end
    @(negedge clk); dmem_resp = 1'b1; imem_resp = 1'b1; #1;
    checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL both_resp: got %b want %b", outs, RUN_ALL); end
    @(negedge clk); idle(); #1;
    checks++; if (state_dbg !== S_RUN) begin errors++; $display("FAIL both_resp_state: got %0d want %0d", state_dbg, S_RUN); end
  endtask

  task automatic test_drop();
    do_reset();
    @(negedge clk); ex_br_taken = 1'b1; imem_read = 1'b1; #1;
    checks++; if (outs !== FLUSH) begin errors++; $display("FAIL drop_redirect: got %b want %b", outs, FLUSH); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); ex_br_taken = 1'b0; #1;
      checks++; if (state_dbg !== S_DROP) begin errors++; $display("FAIL drop_state c%0d: got %0d want %0d", i, state_dbg, S_DROP); end
      checks++; if (outs !== DROPWAIT) begin errors++; $display("FAIL drop_wait c%0d: got %b want %b", i, outs, DROPWAIT); end
    end
    @(negedge clk); imem_resp = 1'b1; #1;
    checks++; if (outs !== DROPRESP) begin errors++; $display("FAIL drop_discard: got %b want %b", outs, DROPRESP); end
    @(negedge clk); idle(); #1;
    checks++; if (state_dbg !== S_RUN) begin errors++; $display("FAIL drop_back_run: got %0d want %0d", state_dbg, S_RUN); end
    checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL drop_after: got %b want %b", outs, RUN_ALL); end
    exp_v = 32'(PERF_ON);
    checks++; if (perf_flush !== exp_v) begin errors++; $display("FAIL drop_perf_flush: got %0d want %0d", perf_flush, exp_v); end
    exp_v = 32'(2 * PERF_ON);
    checks++; if (perf_stall !== exp_v) begin errors++; $display("FAIL drop_perf_stall: got %0d want %0d", perf_stall, exp_v); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk); ex_br_taken = 1'b1; imem_read = 1'b1; #1;
    @(negedge clk); #1;
    checks++; if (outs !== FLUSH) begin errors++; $display("FAIL b2b_second_redirect: got %b want %b", outs, FLUSH); end
    @(negedge clk); ex_br_taken = 1'b0; #1;
    checks++; if (state_dbg !== S_DROP) begin errors++; $display("FAIL b2b_stay_drop: got %0d want %0d", state_dbg, S_DROP); end
    checks++; if (outs !== DROPWAIT) begin errors++; $display("FAIL b2b_wait: got %b want %b", outs, DROPWAIT); end
    @(negedge clk); imem_resp = 1'b1; #1;
    checks++; if (outs !== DROPRESP) begin errors++; $display("FAIL b2b_discard: got %b want %b", outs, DROPRESP); end
    @(negedge clk); idle(); #1;
    checks++; if (state_dbg !== S_RUN) begin errors++; $display("FAIL b2b_back_run: got %0d want %0d", state_dbg, S_RUN); end
    exp_v = 32'(2 * PERF_ON);
    checks++; if (perf_flush !== exp_v) begin errors++; $display("FAIL b2b_perf_flush: got %0d want %0d", perf_flush, exp_v); end
  endtask

  task automatic test_redirect_in_dstall();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_req = 1'b1; ex_br_taken = 1'b1; #1;
      checks++; if (outs !== FREEZE) begin errors++; $display("FAIL rd_dstall_freeze c%0d: got %b want %b", i, outs, FREEZE); end
    end
    @(negedge clk); dmem_resp = 1'b1; #1;
    checks++; if (outs !== FLUSH) begin errors++; $display("FAIL rd_dstall_flush: got %b want %b", outs, FLUSH); end
    @(negedge clk); idle(); #1;
    checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL rd_dstall_one_flush: got %b want %b", outs, RUN_ALL); end
    exp_v = 32'(PERF_ON);
    checks++; if (perf_flush !== exp_v) begin errors++; $display("FAIL rd_dstall_perf_flush: got %0d want %0d", perf_flush, exp_v); end
    exp_v = 32'(2 * PERF_ON);
    checks++; if (perf_stall !== exp_v) begin errors++; $display("FAIL rd_dstall_perf_stall: got %0d want %0d", perf_stall, exp_v); end
  endtask

  task automatic test_reset_in_drop();
    do_reset();
    @(negedge clk); ex_br_taken = 1'b1; imem_read = 1'b1; #1;
    @(negedge clk); ex_br_taken = 1'b0; #1;
    checks++; if (state_dbg !== S_DROP) begin errors++; $display("FAIL rst_drop_entered: got %0d want %0d", state_dbg, S_DROP); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (outs !== ZERO) begin errors++; $display("FAIL rst_drop_outs: got %b want %b", outs, ZERO); end
    @(negedge clk); rst = 1'b0; imem_resp = 1'b1; #1;
    checks++; if (state_dbg !== S_RUN) begin errors++; $display("FAIL rst_drop_state: got %0d want %0d", state_dbg, S_RUN); end
    checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL rst_drop_accept: got %b want %b", outs, RUN_ALL); end
    checks++; if (perf_flush !== 32'd0) begin errors++; $display("FAIL rst_drop_perf_clear: got %0d want 0", perf_flush); end
    @(negedge clk); idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_x0();
    test_dstall();
    test_istall();
    test_drop();
    test_back_to_back();
    test_redirect_in_dstall();
    test_reset_in_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
